mem_fetch_ctrl: RTL

- Memory access sequencer between the multicycle control FSM and the unified instruction/data memory.
- Accepts one read or write request per access, selects the address from PC or ALU result (IouD), and waits a fixed memory latency.
- Captures the read word in a memory data register (MDR), and loads the instruction register (IR) on EscreveIR.
- Drives the opcode/funct fields consumed by the control unit and replaces the control unit's fixed ESPERA cycle with a real done handshake.

---
 rtl/mips_pkg.sv | 19 +
 rtl/instr_reg.sv | 36 +++
 rtl/mem_fetch_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS memory/decode path.
package mips_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } fetch_state_e;

    // Instruction field positions.
    localparam int unsigned OP_HI    = 31;
    localparam int unsigned OP_LO    = 26;
    localparam int unsigned FUNCT_HI = 5;
    localparam int unsigned FUNCT_LO = 0;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
    localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/instr_reg.sv
// Instruction register with load enable and opcode/funct field extraction.
module instr_reg
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] data_i,
    output logic [31:0] ir_o,
    output logic [5:0]  opcode_o,
    output logic [5:0]  funct_o
);

    logic [31:0] ir_q;
    logic [31:0] ir_d;

    always_comb begin
        ir_d = ir_q;
        if (load_i) begin
            ir_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign ir_o     = ir_q;
    assign opcode_o = ir_q[OP_HI:OP_LO];
    assign funct_o  = ir_q[FUNCT_HI:FUNCT_LO];

endmodule

// File: rtl/mem_fetch_ctrl.sv
// Memory access sequencer: one request per access, fixed latency, MDR capture and IR load.
module mem_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              IouD,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              EscreveIR,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       ir,
    output logic [5:0]        OPcode,
    output logic [5:0]        funct,
    output logic              proto_err,
    output logic              align_err
);

    localparam logic [LAT_CNT_W-1:0] CntInit = LAT_CNT_W'(MEM_LAT - 1);

    fetch_state_e         state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    mdr_q, mdr_d;
    logic                 we_q, we_d;
    logic                 first_q, first_d;
    logic                 proto_q, proto_d;
    logic                 align_q, align_d;
    logic [DATA_W-1:0]    sel_addr;

    assign sel_addr = IouD ? alu_out : pc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        we_d    = we_q;
        first_d = first_q;
        proto_d = proto_q;
        align_d = align_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = {sel_addr[DATA_W-1:2], 2'b00};
                    wdata_d = wr_data;
                    we_d    = req_write;
                    cnt_d   = CntInit;
                    first_d = 1'b1;
                    state_d = StWait;
                    if (sel_addr[1:0] != 2'b00) begin
                        align_d = 1'b1;
                    end
                end
            end
            StWait: begin
                first_d = 1'b0;
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // No queueing: a request outside IDLE is dropped and flagged.
        if (req_valid && (state_q != StIdle)) begin
            proto_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
            we_q    <= 1'b0;
            first_q <= 1'b0;
            proto_q <= 1'b0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
            we_q    <= we_d;
            first_q <= first_d;
            proto_q <= proto_d;
            align_q <= align_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state_q == StWait) && first_q && we_q;
    assign mdr       = mdr_q;
    assign proto_err = proto_q;
    assign align_err = align_q;

    instr_reg u_instr_reg (
        .clk_i    (clock),
        .rst_i    (reset),
        .load_i   (EscreveIR),
        .data_i   (mdr_q[31:0]),
        .ir_o     (ir),
        .opcode_o (OPcode),
        .funct_o  (funct)
    );

endmodule
